rv32_d_instr_encoder: RTL and testbench

- Encode side of the decode-stage opcode/format map: turns field-level instruction requests (format, opcode, registers, funct, immediate) into 32-bit RV32 instruction words.
- Encoded words are buffered in a small FIFO and issued over a valid/ready stream toward fetch/decode.
- Used by the debug program-buffer injector and by self-test sequences.
- Checks immediates for range and alignment per format, and flags illegal requests.

---
 rtl/rv32_d_instr_encoder_pkg.sv | 47 ++++
 rtl/rv32_d_instr_fifo.sv | 45 ++++
 rtl/rv32_d_instr_encoder.sv | 103 ++++++++++
 tb/tb_rv32_d_instr_encoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_d_instr_encoder_pkg.sv
// rv32_d_instr_encoder_pkg: shared format codes, request bundle and opcode constants
package rv32_d_instr_encoder_pkg;
  // I/S/B/J/U match the decoder's imm_src encoding
  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_S   = 3'd1,
    FMT_B   = 3'd2,
    FMT_J   = 3'd3,
    FMT_U   = 3'd4,
    FMT_R   = 3'd5,
    FMT_R4  = 3'd6,
    FMT_BAD = 3'd7
  } fmt_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } req_t;

  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
  localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_MADD   = 7'h43;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;
  localparam logic [6:0] OPCODE_JAL    = 7'h6f;
  localparam logic [6:0] OPCODE_SYSTEM = 7'h73;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // True when imm[31:msb] are all equal, i.e. the value sign-extends from bit msb
  function automatic logic sext_ok(input logic [31:0] imm, input int msb);
    logic signed [31:0] w_sh;
    w_sh = $signed(imm) >>> msb;
    return (w_sh == 32'sd0) || (w_sh == -32'sd1);
  endfunction
endpackage

// File: rtl/rv32_d_instr_fifo.sv
// rv32_d_instr_fifo: DEPTH x W synchronous FIFO with a registered head word
module rv32_d_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_valid,
  output logic [W-1:0] o_rdata
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr, r_rd;
  logic [AW:0]  w_wr_nxt, w_rd_nxt;
  logic         w_push, w_pop;

  assign o_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_valid  = r_wr != r_rd;
  assign w_push   = i_push && !o_full;
  assign w_pop    = i_pop && o_valid;
  assign w_wr_nxt = r_wr + (AW+1)'(w_push);
  assign w_rd_nxt = r_rd + (AW+1)'(w_pop);

  // Storage array; no reset needed since pointers gate visibility
  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_wdata;

  // Pointers and head register; the head bypasses the write port when it lands on an empty FIFO
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      o_rdata <= '0;
    end else begin
      r_wr <= w_wr_nxt;
      r_rd <= w_rd_nxt;
      if (w_wr_nxt != w_rd_nxt)
        o_rdata <= (w_push && r_wr[AW-1:0] == w_rd_nxt[AW-1:0]) ? i_wdata : r_mem[w_rd_nxt[AW-1:0]];
    end
endmodule

// File: rtl/rv32_d_instr_encoder.sv
// rv32_d_instr_encoder: encodes field-level requests into RV32 words and streams them out through a FIFO
module rv32_d_instr_encoder
  import rv32_d_instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_fmt_i,
  input  logic [6:0]       req_opcode_i,
  input  logic [4:0]       req_rd_i,
  input  logic [4:0]       req_rs1_i,
  input  logic [4:0]       req_rs2_i,
  input  logic [4:0]       req_rs3_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [6:0]       req_funct7_i,
  input  logic [31:0]      req_imm_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [31:0]      instr_o,
  output logic             enc_err_o,
  output logic             err_sticky_o,
  output logic [CNT_W-1:0] issued_cnt_o
);
  req_t        w_req;
  logic [31:0] w_enc, w_wdata;
  logic        w_legal, w_full, w_push, w_pop;

  assign w_req = '{fmt: fmt_e'(req_fmt_i), opcode: req_opcode_i, rd: req_rd_i, rs1: req_rs1_i,
                   rs2: req_rs2_i, rs3: req_rs3_i, funct3: req_funct3_i, funct7: req_funct7_i,
                   imm: req_imm_i};

  // Field packing and per-format immediate range/alignment check
  always_comb begin
    w_enc   = '0;
    w_legal = 1'b0;
    case (w_req.fmt)
      FMT_I: begin
        w_enc   = {w_req.imm[11:0], w_req.rs1, w_req.funct3, w_req.rd, w_req.opcode};
        w_legal = sext_ok(w_req.imm, 11);
      end
      FMT_S: begin
        w_enc   = {w_req.imm[11:5], w_req.rs2, w_req.rs1, w_req.funct3, w_req.imm[4:0], w_req.opcode};
        w_legal = sext_ok(w_req.imm, 11);
      end
      FMT_B: begin
        w_enc   = {w_req.imm[12], w_req.imm[10:5], w_req.rs2, w_req.rs1, w_req.funct3,
                   w_req.imm[4:1], w_req.imm[11], w_req.opcode};
        w_legal = sext_ok(w_req.imm, 12) && !w_req.imm[0];
      end
      FMT_J: begin
        w_enc   = {w_req.imm[20], w_req.imm[10:1], w_req.imm[11], w_req.imm[19:12], w_req.rd, w_req.opcode};
        w_legal = sext_ok(w_req.imm, 20) && !w_req.imm[0];
      end
      FMT_U: begin
        w_enc   = {w_req.imm[31:12], w_req.rd, w_req.opcode};
        w_legal = w_req.imm[11:0] == 12'h000;
      end
      FMT_R: begin
        w_enc   = {w_req.funct7, w_req.rs2, w_req.rs1, w_req.funct3, w_req.rd, w_req.opcode};
        w_legal = 1'b1;
      end
      FMT_R4: begin
        w_enc   = {w_req.rs3, w_req.funct7[1:0], w_req.rs2, w_req.rs1, w_req.funct3, w_req.rd, w_req.opcode};
        w_legal = 1'b1;
      end
      default: ;
    endcase
    w_legal = w_legal && (w_req.opcode[1:0] == 2'b11);
  end

  // Illegal requests push an all-zero word so the decoder sees an invalid opcode
  assign w_wdata     = w_legal ? w_enc : 32'h0000_0000;
  assign req_ready_o = !w_full;
  assign w_push      = req_valid_i && !w_full;
  assign w_pop       = instr_valid_o && instr_ready_i;

  rv32_d_instr_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_valid (instr_valid_o),
    .o_rdata (instr_o)
  );

  // Error pulse, sticky error flag and issued-word counter
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      enc_err_o    <= 1'b0;
      err_sticky_o <= 1'b0;
      issued_cnt_o <= '0;
    end else begin
      enc_err_o    <= w_push && !w_legal;
      err_sticky_o <= err_sticky_o || (w_push && !w_legal);
      issued_cnt_o <= issued_cnt_o + CNT_W'(w_pop);
    end
endmodule

// File: tb/tb_rv32_d_instr_encoder.sv
// tb_rv32_d_instr_encoder: random and directed checks of the encoder against a queue-based reference model
module tb_rv32_d_instr_encoder;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid_i, req_ready_o;
  logic [2:0]       req_fmt_i;
  logic [6:0]       req_opcode_i;
  logic [4:0]       req_rd_i, req_rs1_i, req_rs2_i, req_rs3_i;
  logic [2:0]       req_funct3_i;
  logic [6:0]       req_funct7_i;
  logic [31:0]      req_imm_i;
  logic             instr_valid_o, instr_ready_i;
  logic [31:0]      instr_o;
  logic             enc_err_o, err_sticky_o;
  logic [CNT_W-1:0] issued_cnt_o;

  rv32_d_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_fmt_i     (req_fmt_i),
    .req_opcode_i  (req_opcode_i),
    .req_rd_i      (req_rd_i),
    .req_rs1_i     (req_rs1_i),
    .req_rs2_i     (req_rs2_i),
    .req_rs3_i     (req_rs3_i),
    .req_funct3_i  (req_funct3_i),
    .req_funct7_i  (req_funct7_i),
    .req_imm_i     (req_imm_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .enc_err_o     (enc_err_o),
    .err_sticky_o  (err_sticky_o),
    .issued_cnt_o  (issued_cnt_o)
  );

  always #5 clk = ~clk;

  int          total = 0, bad = 0;
  logic [31:0] q[$];
  logic [31:0] last_head = '0;
  logic [15:0] cnt = '0;
  logic        sticky = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  function automatic logic ref_legal(input logic [31:0] fmt, input logic [31:0] op, input logic [31:0] imm);
    int  s;
    logic ok;
    s = imm;
    case (fmt)
      0, 1:    ok = s >= -2048 && s <= 2047;
      2:       ok = s >= -4096 && s <= 4095 && (s % 2 == 0);
      3:       ok = s >= -1048576 && s <= 1048575 && (s % 2 == 0);
      4:       ok = (imm % 4096) == 0;
      5, 6:    ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok && (op % 4 == 3);
  endfunction

  function automatic logic [31:0] ref_enc(input logic [31:0] fmt, op, rd, rs1, rs2, rs3, f3, f7, imm);
    logic [31:0] regs;
    regs = (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
    case (fmt)
      0: return ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      1: return (((imm >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((imm & 32'h1f) << 7) | op;
      2: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (rs2 << 20) | (rs1 << 15) |
                (f3 << 12) | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 1) << 7) | op;
      3: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21) | (((imm >> 11) & 1) << 20) |
                (((imm >> 12) & 32'hff) << 12) | (rd << 7) | op;
      4: return (imm & 32'hfffff000) | (rd << 7) | op;
      5: return (f7 << 25) | regs;
      6: return (rs3 << 27) | ((f7 & 3) << 25) | regs;
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_req(input logic v, input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    req_valid_i  = v;
    req_fmt_i    = fmt;
    req_opcode_i = op;
    req_rd_i     = rd;
    req_rs1_i    = rs1;
    req_rs2_i    = rs2;
    req_rs3_i    = 5'd0;
    req_funct3_i = 3'd0;
    req_funct7_i = 7'd0;
    req_imm_i    = imm;
  endtask

  task automatic rand_req();
    int s;
    req_valid_i  = $urandom_range(0, 9) < 7;
    req_fmt_i    = 3'($urandom_range(0, 7));
    req_opcode_i = ($urandom_range(0, 9) == 0) ? 7'($urandom) : {5'($urandom), 2'b11};
    req_rd_i     = 5'($urandom);
    req_rs1_i    = 5'($urandom);
    req_rs2_i    = 5'($urandom);
    req_rs3_i    = 5'($urandom);
    req_funct3_i = 3'($urandom);
    req_funct7_i = 7'($urandom);
    case ($urandom_range(0, 3))
      0: begin s = int'($urandom_range(0, 8191)) - 4096; req_imm_i = s; end
      1: req_imm_i = $urandom;
      2: req_imm_i = $urandom & 32'hfffff000;
      default: begin s = (int'($urandom_range(0, 4194303)) - 2097152) & ~1; req_imm_i = s; end
    endcase
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model across the edge
  task automatic cycle();
    logic        push, pop, il;
    logic [31:0] w;
    @(negedge clk);
    chk("valid", instr_valid_o, q.size() != 0);
    chk("data", instr_o, q.size() != 0 ? q[0] : last_head);
    chk("ready", req_ready_o, q.size() < DEPTH);
    push = req_valid_i && q.size() < DEPTH;
    pop  = instr_ready_i && q.size() != 0;
    il   = !ref_legal(req_fmt_i, req_opcode_i, req_imm_i);
    w    = il ? 32'h0 : ref_enc(req_fmt_i, req_opcode_i, req_rd_i, req_rs1_i, req_rs2_i, req_rs3_i,
                                req_funct3_i, req_funct7_i, req_imm_i);
    @(posedge clk);
    #1;
    if (pop) begin
      last_head = q.pop_front();
      cnt++;
    end
    if (push) q.push_back(w);
    sticky = sticky || (push && il);
    chk("err", enc_err_o, push && il);
    chk("sticky", err_sticky_o, sticky);
    chk("cnt", issued_cnt_o, cnt);
  endtask

  // Asynchronous assert between edges, release on a falling edge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_cnt", issued_cnt_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_err", enc_err_o, 0);
    chk("rst_sticky", err_sticky_o, 0);
    q.delete();
    last_head = '0;
    cnt = '0;
    sticky = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    instr_ready_i = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    instr_ready_i = 1'b1;
    set_req(1, 3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 32'd5);
    cycle();
    chk("addi", instr_o, 32'h0050_0093);
    chk("addi_err", enc_err_o, 0);
    set_req(1, 3'b010, 7'h63, 5'd0, 5'd1, 5'd2, -32'sd4);
    cycle();
    chk("beq", instr_o, 32'hFE20_8EE3);
    set_req(1, 3'b010, 7'h63, 5'd0, 5'd1, 5'd2, 32'd3);
    cycle();
    chk("beq_bad", instr_o, 32'h0);
    chk("beq_bad_err", enc_err_o, 1);
    chk("beq_bad_sticky", err_sticky_o, 1);
    set_req(1, 3'b011, 7'h6f, 5'd1, 5'd0, 5'd0, 32'd8);
    cycle();
    chk("jal", instr_o, 32'h0080_00EF);
    chk("jal_err", enc_err_o, 0);
    set_req(1, 3'b100, 7'h37, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    cycle();
    chk("lui", instr_o, 32'h1234_52B7);
    set_req(1, 3'b100, 7'h37, 5'd5, 5'd0, 5'd0, 32'h1234_5001);
    cycle();
    chk("lui_bad", instr_o, 32'h0);
    chk("lui_bad_err", enc_err_o, 1);
    req_valid_i = 1'b0;
    repeat (2) cycle();

    do_reset();
    instr_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(1, 3'b000, 7'h13, 5'(i + 1), 5'd0, 5'd0, 32'(i + 1));
      cycle();
    end
    chk("bp_full", req_ready_o, 0);
    chk("bp_hold", instr_o, 32'h0010_0093);
    req_valid_i   = 1'b0;
    instr_ready_i = 1'b1;
    cycle();
    chk("bp_ready_after_pop", req_ready_o, 1);
    repeat (4) cycle();
    chk("bp_cnt", issued_cnt_o, 32'd4);

    instr_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(1, 3'b101, 7'h33, 5'(i), 5'(i + 3), 5'(i + 7), 32'd0);
      cycle();
    end
    instr_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_req(1, 3'b101, 7'h33, 5'($urandom), 5'($urandom), 5'($urandom), 32'd0);
      req_funct7_i = 7'($urandom);
      cycle();
      chk("sim_valid", instr_valid_o, 1);
    end
    req_valid_i = 1'b0;
    repeat (3) cycle();

    for (int i = 0; i < 1500; i++) begin
      rand_req();
      instr_ready_i = $urandom_range(0, 9) < 6;
      cycle();
    end
    req_valid_i   = 1'b0;
    instr_ready_i = 1'b1;
    repeat (DEPTH + 1) cycle();

    instr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1, 3'b001, 7'h23, 5'd0, 5'(i), 5'(i + 1), 32'(i * 4));
      cycle();
    end
    req_valid_i = 1'b0;
    do_reset();
    instr_ready_i = 1'b1;
    repeat (3) cycle();
    chk("post_rst_empty", instr_valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
